// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared definitions for the shift arbiter: datapath widths,
//                shift-type codes and the arbiter state encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

   localparam int DATA_W = 32;
   localparam int TYPE_W = 2;
   localparam int AMNT_W = 5;

   // Shift-type codes carried on req_type
   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_ASL = 2'b01;  // identical to LSL
   localparam logic [1:0] SH_LSR = 2'b10;
   localparam logic [1:0] SH_ASR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Scans req starting at
//                ptr and wrapping modulo NREQ; the first set bit wins.
//  Ports       : req_i   [NREQ]  request vector
//                ptr_i   [IDW]   index with highest priority this cycle
//                grant_o [NREQ]  one-hot winner (all zero if no request)
//                idx_o   [IDW]   binary index of the winner
//                any_o   [1]     at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IDW-1:0]  idx_o,
   output logic            any_o
);

   logic w_found;

   // Outer loop walks priority order (ptr, ptr+1, ...); the inner loop maps
   // that position back to a constant bit index so no variable bit-select
   // of the request vector is needed.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      w_found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_i[i] && (i == ((int'(ptr_i) + k) % NREQ))) begin
               w_found    = 1'b1;
               grant_o[i] = 1'b1;
               idx_o      = IDW'(i);
            end
         end
      end
   end

   assign any_o = w_found;

endmodule : rr_pick
`default_nettype wire

// File: rtl/shift_arbiter_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : shifter
//  Description : Combinational 32-bit barrel shifter. LSL/ASL/LSR zero-fill,
//                ASR sign-fills from bit 31. Output is zero when disabled.
//  Ports       : en_i   [1]   enable
//                data_i [32]  operand
//                type_i [2]   shift type code
//                amnt_i [5]   shift amount 0..31
//                res_o  [32]  shifted result
//  Revision    : 1.0 - initial release
// ============================================================================
module shifter
   import shift_pkg::*;
(
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [TYPE_W-1:0] type_i,
   input  logic [AMNT_W-1:0] amnt_i,
   output logic [DATA_W-1:0] res_o
);

   always_comb begin
      res_o = '0;
      if (en_i) begin
         case (type_i)
            SH_LSL, SH_ASL: res_o = data_i << amnt_i;
            SH_LSR:         res_o = data_i >> amnt_i;
            SH_ASR:         res_o = DATA_W'($signed(data_i) >>> amnt_i);
            default:        res_o = '0;
         endcase
      end
   end

endmodule : shifter
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shift_arbiter
//  Description : Shares one shifter between NREQ requesters. Round-robin
//                grant, operands latched on accept, shift executed for one
//                cycle, result held on a shared response channel tagged with
//                the requester id until the consumer takes it.
//  Ports       : clk        [1]        clock, rising edge
//                rst_n      [1]        synchronous reset, active low
//                req_valid  [NREQ]     per-requester request pending
//                req_ready  [NREQ]     one-hot grant
//                req_data   [NREQ*32]  operands, requester i at [32*i +: 32]
//                req_type   [NREQ*2]   shift types, [2*i +: 2]
//                req_amnt   [NREQ*5]   shift amounts, [5*i +: 5]
//                rsp_valid  [1]        result available
//                rsp_ready  [1]        consumer accepts result
//                rsp_data   [32]       shifted result
//                rsp_id     [IDW]      owner of rsp_data
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_arbiter
   import shift_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*DATA_W-1:0] req_data,
   input  logic [NREQ*TYPE_W-1:0] req_type,
   input  logic [NREQ*AMNT_W-1:0] req_amnt,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_W-1:0]      rsp_data,
   output logic [IDW-1:0]         rsp_id
);

   state_t            state_q,    state_d;
   logic [IDW-1:0]    ptr_q,      ptr_d;
   logic [DATA_W-1:0] op_data_q,  op_data_d;
   logic [TYPE_W-1:0] op_type_q,  op_type_d;
   logic [AMNT_W-1:0] op_amnt_q,  op_amnt_d;
   logic [IDW-1:0]    op_id_q,    op_id_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [IDW-1:0]    rsp_id_q,   rsp_id_d;

   logic [NREQ-1:0]   w_grant;
   logic [IDW-1:0]    w_idx;
   logic              w_any;
   logic              w_can_accept;
   logic              w_accept;
   logic [DATA_W-1:0] w_sel_data;
   logic [TYPE_W-1:0] w_sel_type;
   logic [AMNT_W-1:0] w_sel_amnt;
   logic              w_shift_en;
   logic [DATA_W-1:0] w_shift_res;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_pick (
      .req_i   (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (w_grant),
      .idx_o   (w_idx),
      .any_o   (w_any)
   );

   assign w_shift_en = (state_q == ST_EXEC);

   shifter u_shifter (
      .en_i   (w_shift_en),
      .data_i (op_data_q),
      .type_i (op_type_q),
      .amnt_i (op_amnt_q),
      .res_o  (w_shift_res)
   );

   // A result can be replaced in the same cycle it is consumed, which is
   // what gives back-to-back throughput of one result every two cycles.
   assign w_can_accept = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
   // rst_n gates the grant so nothing is accepted while reset is asserted.
   assign w_accept     = w_can_accept && w_any && rst_n;
   assign req_ready    = w_accept ? w_grant : '0;

   // Operand mux for the winning requester, built from constant slices.
   always_comb begin
      w_sel_data = '0;
      w_sel_type = '0;
      w_sel_amnt = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_idx == IDW'(i)) begin
            w_sel_data = req_data[DATA_W*i +: DATA_W];
            w_sel_type = req_type[TYPE_W*i +: TYPE_W];
            w_sel_amnt = req_amnt[AMNT_W*i +: AMNT_W];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      op_data_d   = op_data_q;
      op_type_d   = op_type_q;
      op_amnt_d   = op_amnt_q;
      op_id_d     = op_id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;

      // Shared accept path for IDLE and for RESP-with-handshake.
      if (w_accept) begin
         op_data_d = w_sel_data;
         op_type_d = w_sel_type;
         op_amnt_d = w_sel_amnt;
         op_id_d   = w_idx;
         ptr_d     = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_data_d  = w_shift_res;
            rsp_id_d    = op_id_q;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = w_accept ? ST_EXEC : ST_IDLE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         op_data_q   <= '0;
         op_type_q   <= '0;
         op_amnt_q   <= '0;
         op_id_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         op_data_q   <= op_data_d;
         op_type_q   <= op_type_d;
         op_amnt_q   <= op_amnt_d;
         op_id_q     <= op_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;

endmodule : shift_arbiter
`default_nettype wire
